// File: rtl/timer_counter_if.sv
// timer_counter_if: bus-side signals of the timer_counter device.
// The master modport is the bridge/CPU side; the slave modport is the timer.
interface timer_counter_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  byteEn;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (
    output sel, we, addr, byteEn, wd,
    input  rd, irq
  );

  modport slave (
    input  sel, we, addr, byteEn, wd,
    output rd, irq
  );
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with interrupt output.
// Word registers: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved (reads 0).
// CTRL: bit0 EN, bits[2:1] MODE (01 auto-reload, anything else one-shot), bit3 IM.
// Build macro TIMER_PRESCALE_EN adds an 8-bit prescale field PSC in CTRL[11:4];
// each COUNT step then lasts PSC+1 cycles. Without it CTRL[11:4] reads 0.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,   // asynchronous, active-low
  timer_counter_if.slave bus
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

`ifdef TIMER_PRESCALE_EN
  localparam logic [11:0] CTRL_MASK = 12'hFFF;
`else
  localparam logic [11:0] CTRL_MASK = 12'h00F;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  preset_q, preset_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              int_q, int_d;
  logic              int_set;
  logic              step;
  logic              wr_ctrl;
  logic              wr_preset;
  logic [11:0]       ctrl_wdata;
  logic [CNT_W-1:0]  preset_wdata;
  logic [31:0]       rd_data;

  logic              en;
  logic              mode_auto;
  logic              im;

  // Zero-extend a counter-width value onto the 32-bit data bus.
  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // Replace the byte lanes selected by be with the matching lanes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  // Keep only the implemented CTRL bits; the rest are read-only zero.
  function automatic logic [11:0] to_ctrl(input logic [31:0] v);
    return v[11:0] & CTRL_MASK;
  endfunction

  // Drop bus bits above the counter width.
  function automatic logic [CNT_W-1:0] to_cnt(input logic [31:0] v);
    return v[CNT_W-1:0];
  endfunction

  assign en        = ctrl_q[0];
  assign mode_auto = (ctrl_q[2:1] == 2'b01);
  assign im        = ctrl_q[3];

  assign wr_ctrl   = bus.sel & bus.we & (bus.addr == A_CTRL);
  assign wr_preset = bus.sel & bus.we & (bus.addr == A_PRESET);

  assign ctrl_wdata   = to_ctrl(merge_bytes({20'b0, ctrl_q}, bus.wd, bus.byteEn));
  assign preset_wdata = to_cnt(merge_bytes(zext(preset_q), bus.wd, bus.byteEn));

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_q, psc_d;

  // A COUNT step is taken once the prescaler has reached PSC; a PSC lowered
  // below the running prescale value steps immediately rather than wrapping.
  assign step = (psc_q >= ctrl_q[11:4]);

  // Prescale counter: cleared on LOAD, advances every enabled CNT cycle.
  always_comb begin
    psc_d = psc_q;
    if (state_q == ST_LOAD) begin
      psc_d = '0;
    end else if ((state_q == ST_CNT) && en) begin
      psc_d = step ? 8'd0 : psc_q + 8'd1;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) psc_q <= '0;
    else        psc_q <= psc_d;
  end
`else
  assign step = 1'b1;
`endif

  // Read mux: purely combinational from addr, independent of sel.
  always_comb begin
    rd_data = '0;
    case (bus.addr)
      A_CTRL:   rd_data = {20'b0, ctrl_q};
      A_PRESET: rd_data = zext(preset_q);
      A_COUNT:  rd_data = zext(count_q);
      default:  rd_data = '0;
    endcase
  end

  assign bus.rd  = rd_data;
  assign bus.irq = im & int_q;

  // Next-state logic: FSM step first, then bus writes layered on top.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    int_d    = int_q;
    int_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        int_d   = 1'b0;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (step) begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else begin
            count_d = '0;
            int_d   = 1'b1;
            int_set = 1'b1;
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (mode_auto) begin
          int_d   = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_preset) preset_d = preset_wdata;

    // A CTRL write overrides the one-shot EN clear and acknowledges the
    // interrupt, unless the counter expires on this very edge.
    if (wr_ctrl) begin
      ctrl_d = ctrl_wdata;
      if (!int_set) int_d = 1'b0;
    end
  end

  // State and register file, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      int_q    <= int_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter.
// Table-driven register vectors, directed multi-cycle sequences, and
// randomized runs checked against a closed-form timing model.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;

  timer_counter_if bus_if ();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_0FFF;
  localparam bit          HAS_PSC   = 1'b1;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
  localparam bit          HAS_PSC   = 1'b0;
`endif

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_if.sel    = 1'b1;
    bus_if.we     = 1'b1;
    bus_if.addr   = a;
    bus_if.wd     = d;
    bus_if.byteEn = be;
    @(posedge clk);
    #1;
    bus_if.sel    = 1'b0;
    bus_if.we     = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    check(name, bus_if.rd, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    check(name, {31'b0, bus_if.irq}, {31'b0, exp});
  endtask

  task automatic do_reset();
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Closed-form expectation for edge e after the enabling CTRL write (edge 0).
  // The first period starts with the load at edge 2 and lasts T cycles;
  // the expiry edge is T after the write.
  function automatic void model(input int e, input int p, input int s, input int mode,
                                input bit im_b, output int cnt, output bit irq_e,
                                output bit en_cleared);
    int pe, t, j;
    pe = (p == 0) ? 1 : p;
    t  = pe * (s + 1) + 2;
    cnt = 0;
    irq_e = 1'b0;
    en_cleared = 1'b0;
    if (e < 2) return;
    if (mode != 1) begin
      if (e >= t) begin
        cnt = 0;
        irq_e = im_b;
        en_cleared = (e >= t + 1);
      end else begin
        j = e - 2;
        cnt = (p == 0) ? 0 : p - j / (s + 1);
      end
    end else begin
      j = (e - 2) % t;
      if (j < t - 2) cnt = (p == 0) ? 0 : p - j / (s + 1);
      else           cnt = 0;
      irq_e = im_b && (j == t - 2);
    end
  endfunction

  initial begin
    bus_if.sel    = 1'b0;
    bus_if.we     = 1'b0;
    bus_if.addr   = 2'd0;
    bus_if.byteEn = 4'h0;
    bus_if.wd     = 32'h0;
    reset         = 1'b0;

    vecs.push_back('{2'd1, 4'b0001, 32'hFFFF_FFFF, 32'h0000_00FF});
    vecs.push_back('{2'd1, 4'b0100, 32'h1234_5678, 32'h0034_00FF});
    vecs.push_back('{2'd1, 4'b1010, 32'hAABB_CCDD, 32'hAA34_CCFF});
    vecs.push_back('{2'd1, 4'b0000, 32'hFFFF_FFFF, 32'hAA34_CCFF});
    vecs.push_back('{2'd2, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000});
    vecs.push_back('{2'd3, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{2'd0, 4'b1111, 32'hFFFF_FFFE, 32'hFFFF_FFFE & CTRL_MASK});
    vecs.push_back('{2'd0, 4'b0001, 32'h0000_0000, 32'h0000_0F00 & CTRL_MASK});
    vecs.push_back('{2'd0, 4'b1110, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{2'd1, 4'b1111, 32'h0000_0000, 32'h0000_0000});

    tick();
    tick();
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, 32'h0);
    rd_chk("rst_count", 2'd2, 32'h0);
    irq_chk("rst_irq", 1'b0);
    reset = 1'b1;
    tick();

    // Register write/readback vectors.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wd, vecs[i].be);
      rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // One-shot, PRESET=3, held interrupt and acknowledge.
    do_reset();
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(); tick();
    rd_chk("os_cnt_e2", 2'd2, 32'd3);
    tick();
    rd_chk("os_cnt_e3", 2'd2, 32'd2);
    tick();
    rd_chk("os_cnt_e4", 2'd2, 32'd1);
    irq_chk("os_irq_e4", 1'b0);
    tick();
    irq_chk("os_irq_e5", 1'b1);
    rd_chk("os_cnt_e5", 2'd2, 32'd0);
    tick();
    rd_chk("os_ctrl_e6", 2'd0, 32'h8);
    irq_chk("os_irq_e6", 1'b1);
    tick();
    irq_chk("os_irq_e7", 1'b1);
    wr(2'd0, 32'h8, 4'hF);
    irq_chk("os_ack", 1'b0);

    // Asynchronous reset while irq is high.
    do_reset();
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    repeat (5) tick();
    irq_chk("ar_pre_irq", 1'b1);
    #1;
    reset = 1'b0;
    rd_chk("ar_ctrl", 2'd0, 32'h0);
    rd_chk("ar_preset", 2'd1, 32'h0);
    rd_chk("ar_count", 2'd2, 32'h0);
    rd_chk("ar_rsvd", 2'd3, 32'h0);
    irq_chk("ar_irq", 1'b0);
    tick();
    reset = 1'b1;

    // Auto-reload, PRESET=3: pulses at edges 5, 10, 15; then freeze.
    do_reset();
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int e = 1; e <= 17; e++) begin
      tick();
      irq_chk($sformatf("ar_irq_e%0d", e), (e == 5) || (e == 10) || (e == 15));
    end
    wr(2'd0, 32'h2, 4'hF);
    repeat (3) tick();
    rd_chk("frz_cnt", 2'd2, 32'd2);
    rd_chk("frz_ctrl", 2'd0, 32'h2);
    irq_chk("frz_irq", 1'b0);
    wr(2'd2, 32'h55, 4'hF);
    rd_chk("cnt_wr_ign", 2'd2, 32'd2);
    wr(2'd0, 32'h1, 4'hF);
    tick(); tick();
    rd_chk("reen_cnt", 2'd2, 32'd3);
    wr(2'd1, 32'd7, 4'hF);
    rd_chk("preset_live", 2'd2, 32'd2);
    rd_chk("preset_new", 2'd1, 32'd7);

    // PRESET 0 and 1 both expire at edge 3.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(2'd1, p, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      tick(); tick();
      irq_chk($sformatf("p%0d_irq_e2", p), 1'b0);
      tick();
      irq_chk($sformatf("p%0d_irq_e3", p), 1'b1);
    end

    // IM=0 run; CTRL write on the expiry edge loses to the flag set,
    // and a CTRL write in INT keeps its written EN.
    do_reset();
    wr(2'd1, 32'd1, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    tick(); tick();
    irq_chk("sim_irq_e2", 1'b0);
    wr(2'd0, 32'h9, 4'hF);
    irq_chk("sim_irq_e3", 1'b1);
    rd_chk("sim_ctrl_e3", 2'd0, 32'h9);
    wr(2'd0, 32'h9, 4'hF);
    rd_chk("sim_ctrl_e4", 2'd0, 32'h9);
    irq_chk("sim_irq_e4", 1'b0);
    tick(); tick();
    irq_chk("sim_irq_e6", 1'b0);
    tick();
    irq_chk("sim_irq_e7", 1'b1);

    // Prescale field.
    do_reset();
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h29, 4'hF);
`ifdef TIMER_PRESCALE_EN
    for (int e = 1; e <= 8; e++) begin
      int ec;
      tick();
      ec = (e < 2) ? 0 : (e <= 4) ? 2 : (e <= 7) ? 1 : 0;
      rd_chk($sformatf("psc_cnt_e%0d", e), 2'd2, ec);
      irq_chk($sformatf("psc_irq_e%0d", e), e == 8);
    end
`else
    rd_chk("psc_ctrl", 2'd0, 32'h9);
`endif

    // Randomized runs against the closed-form model.
    for (int tr = 0; tr < 30; tr++) begin
      int p, mode, s, psc_w, t, n, ecnt;
      bit im_b, eirq, enc;
      logic [31:0] cw, junk, base;
      do_reset();
      p     = $urandom_range(0, 7);
      mode  = $urandom_range(0, 3);
      im_b  = 1'($urandom_range(0, 1));
      psc_w = $urandom_range(0, 3);
      junk  = $urandom;
      cw    = (junk & 32'hFFFF_F000) | (psc_w << 4) | (32'(im_b) << 3) | (mode << 1) | 32'h1;
      s     = HAS_PSC ? psc_w : 0;
      base  = cw & CTRL_MASK;
      t     = ((p == 0) ? 1 : p) * (s + 1) + 2;
      n     = $urandom_range(t + 2, 2 * t + 6);
      wr(2'd1, p, 4'hF);
      wr(2'd0, cw, 4'hF);
      for (int e = 1; e <= n; e++) begin
        tick();
        model(e, p, s, mode, im_b, ecnt, eirq, enc);
        rd_chk($sformatf("rnd%0d_cnt_e%0d", tr, e), 2'd2, ecnt);
        irq_chk($sformatf("rnd%0d_irq_e%0d", tr, e), eirq);
        rd_chk($sformatf("rnd%0d_ctrl_e%0d", tr, e), 2'd0, enc ? (base & ~32'h1) : base);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
